// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio gain/ramp path.
package audio_pkg;

   localparam int GAIN_W_DEF = 8;
   localparam int GAIN_UNITY = 2 ** (GAIN_W_DEF - 1);

   typedef logic signed [15:0] audio_sample_t;

   function automatic int gain_unity(input int gain_w);
      return 2 ** (gain_w - 1);
   endfunction

   // Clamp a wide signed value into the range of a w-bit two's complement word.
   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/audio_gain_lane.sv
// One channel: gain multiply on v1, floor-shift and saturate on v2.
module audio_gain_lane
   import audio_pkg::*;
#(
   parameter int W      = 16,
   parameter int GAIN_W = 8
) (
   input  logic              clk_audio,
   input  logic              reset,
   input  logic              v1_i,
   input  logic              v2_i,
   input  logic [W-1:0]      sample_i,
   input  logic [GAIN_W-1:0] gain_i,
   output logic [W-1:0]      out_o
);

   localparam int PW = W + GAIN_W + 1;

   logic signed [PW-1:0] prod_q;
   logic signed [PW-1:0] prod_d;
   logic signed [63:0]   shifted;
   logic [W-1:0]         out_d;

   always_comb begin
      // Gain is zero-extended so it is always non-negative in the signed product.
      prod_d  = PW'($signed(sample_i)) * PW'($signed({1'b0, gain_i}));
      shifted = 64'(prod_q) >>> (GAIN_W - 1);
      out_d   = W'(sat_narrow(shifted, W));
   end

   always_ff @(posedge clk_audio or posedge reset) begin
      if (reset) begin
         prod_q <= '0;
         out_o  <= '0;
      end else begin
         if (v1_i) prod_q <= prod_d;
         if (v2_i) out_o  <= out_d;
      end
   end

endmodule

// File: rtl/audio_gain_ramp.sv
// Sample strobe divider, per-sample gain ramp and valid chain feeding CH gain lanes.
module audio_gain_ramp
   import audio_pkg::*;
#(
   parameter int CH        = 2,
   parameter int W         = 16,
   parameter int DIV       = 512,
   parameter int GAIN_W    = 8,
   parameter int RAMP_STEP = 1
) (
   input  logic                clk_audio,
   input  logic                reset,
   input  logic [CH*W-1:0]     audio_in,
   input  logic [GAIN_W-1:0]   gain_target,
   input  logic                mute,
   output logic [CH*W-1:0]     audio_out,
   output logic                sample_valid,
   output logic [GAIN_W-1:0]   gain_cur
);

   localparam int                CW   = $clog2(DIV);
   localparam logic [CW-1:0]     LAST = CW'(DIV - 1);
   localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic              tick_q;
   logic              v1_q;
   logic              v2_q;
   logic              valid_q;
   logic [CH*W-1:0]   in_q;
   logic [GAIN_W-1:0] gain_q;
   logic [GAIN_W-1:0] gain_d;
   logic [GAIN_W-1:0] target;

   always_comb begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      target = mute ? '0 : gain_target;
      gain_d = gain_q;
      // Compare the remaining distance against the step so the sum never overshoots or wraps.
      if (gain_q < target) begin
         gain_d = ((target - gain_q) > STEP) ? gain_q + STEP : target;
      end else if (gain_q > target) begin
         gain_d = ((gain_q - target) > STEP) ? gain_q - STEP : target;
      end
   end

   always_ff @(posedge clk_audio or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         valid_q <= 1'b0;
         in_q    <= '0;
         gain_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         tick_q  <= (cnt_q == LAST);
         v1_q    <= tick_q;
         v2_q    <= v1_q;
         valid_q <= v2_q;
         if (tick_q) begin
            in_q   <= audio_in;
            gain_q <= gain_d;
         end
      end
   end

   assign sample_valid = valid_q;
   assign gain_cur     = gain_q;

   for (genvar k = 0; k < CH; k++) begin : g_lane
      audio_gain_lane #(
         .W      (W),
         .GAIN_W (GAIN_W)
      ) u_lane (
         .clk_audio (clk_audio),
         .reset     (reset),
         .v1_i      (v1_q),
         .v2_i      (v2_q),
         .sample_i  (in_q[k*W +: W]),
         .gain_i    (gain_q),
         .out_o     (audio_out[k*W +: W])
      );
   end

endmodule
